// File: rtl/platform_nios_mul_pkg.sv
// Shared types and helpers for the pipelined Nios multiplier.
// Holds the operation encoding, the base pipeline depth and the
// signed high-word correction used by the sum stage.
package platform_nios_mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,  // low word of the product
    MULXSS = 2'd1,  // high word, signed x signed
    MULXSU = 2'd2,  // high word, signed x unsigned
    MULXUU = 2'd3   // high word, unsigned x unsigned
  } mul_op_e;

  // Partial-product stage plus sum stage.
  localparam int MUL_BASE_LATENCY = 2;

  // Widest operand the correction helper handles; callers zero-extend
  // into it and truncate the result back to their own width, which is
  // exact because the correction is a subtraction modulo 2^WIDTH.
  localparam int MUL_MAX_WIDTH = 64;

  // Turns the unsigned high word into the signed (or mixed) high word.
  // A negative operand in two's complement equals its unsigned value
  // minus 2^WIDTH, so each negative operand costs one copy of the other
  // operand in the upper half of the product.
  function automatic logic [MUL_MAX_WIDTH-1:0] mul_hi_correct(
    input logic [MUL_MAX_WIDTH-1:0] hi,
    input logic [MUL_MAX_WIDTH-1:0] a,
    input logic [MUL_MAX_WIDTH-1:0] b,
    input logic                     a_neg,
    input logic                     b_neg,
    input mul_op_e                  op
  );
    logic [MUL_MAX_WIDTH-1:0] r;
    r = hi;
    case (op)
      MULXSS:  r = hi - (a_neg ? b : '0) - (b_neg ? a : '0);
      MULXSU:  r = hi - (a_neg ? b : '0);
      default: r = hi;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/platform_nios_cpu_mul_pipe_if.sv
// Execute-side request / writeback-side result bundle of the Nios
// multiplier. The CPU pipeline is the master, the multiplier the slave.
interface platform_nios_cpu_mul_pipe_if #(
  parameter int WIDTH = 32
) ();

  logic [WIDTH-1:0] E_src1;
  logic [WIDTH-1:0] E_src2;
  logic             E_mul_valid;
  logic [1:0]       E_mul_op;
  logic             M_en;
  logic             M_flush;
  logic [WIDTH-1:0] W_mul_result;
  logic             W_mul_valid;

  modport master (
    output E_src1, E_src2, E_mul_valid, E_mul_op, M_en, M_flush,
    input  W_mul_result, W_mul_valid
  );

  modport slave (
    input  E_src1, E_src2, E_mul_valid, E_mul_op, M_en, M_flush,
    output W_mul_result, W_mul_valid
  );

endinterface

// File: rtl/platform_nios_mul_partial.sv
// One registered HALF x HALF unsigned multiplier with asynchronous clear
// and clock enable. Small enough to land in a single DSP block.
module platform_nios_mul_partial #(
  parameter int HALF = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [HALF-1:0]   a,
  input  logic [HALF-1:0]   b,
  output logic [2*HALF-1:0] p
);

  // Register the full-width product whenever the pipeline advances.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p <= '0;
    end else if (en) begin
      p <= {{HALF{1'b0}}, a} * {{HALF{1'b0}}, b};
    end
  end

endmodule

// File: rtl/platform_nios_cpu_mul_pipe.sv
// Pipelined integer multiplier for the Nios M/W stages.
// S1 registers half-width partial products, S2 sums them and selects the
// low or (sign-corrected) high word, then PIPE_EXTRA plain output stages.
// M_en stalls every stage, M_flush kills every in-flight operation.
// Build option NIOS_MUL_HI_EN: when defined, the high-high partial and the
// sign correction are built and all four ops are supported; when undefined
// only three partials exist and every op returns the low word.
module platform_nios_cpu_mul_pipe
  import platform_nios_mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PIPE_EXTRA = 0
) (
  input logic                      clk,
  input logic                      reset_n,
  platform_nios_cpu_mul_pipe_if.slave bus
);

  localparam int HALF       = WIDTH / 2;
  localparam int W2         = 2 * WIDTH;
  localparam int OUT_STAGES = MUL_BASE_LATENCY - 1 + PIPE_EXTRA;
`ifdef NIOS_MUL_HI_EN
  localparam int NUM_PARTIALS = 4;
`else
  localparam int NUM_PARTIALS = 3;
`endif

  genvar gi;

  // Partial order: 0 = lo*lo, 1 = lo(A)*hi(B), 2 = hi(A)*lo(B), 3 = hi*hi.
  logic [WIDTH-1:0] part [NUM_PARTIALS];

  for (gi = 0; gi < NUM_PARTIALS; gi++) begin : g_part
    localparam bit A_HI = (gi >= 2);
    localparam bit B_HI = ((gi % 2) == 1);
    platform_nios_mul_partial #(.HALF(HALF)) u_partial (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (bus.M_en),
      .a       (A_HI ? bus.E_src1[WIDTH-1:HALF] : bus.E_src1[HALF-1:0]),
      .b       (B_HI ? bus.E_src2[WIDTH-1:HALF] : bus.E_src2[HALF-1:0]),
      .p       (part[gi])
    );
  end

  // S1 valid bit: flush wins over the enable and also drops the new op.
  logic s1_valid_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
    end else if (bus.M_flush) begin
      s1_valid_reg <= 1'b0;
    end else if (bus.M_en) begin
      s1_valid_reg <= bus.E_mul_valid;
    end
  end

  logic [WIDTH-1:0] s2_next;

`ifdef NIOS_MUL_HI_EN
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  mul_op_e          s1_op_reg;

  // S1 side-band: op and raw operands feed the S2 sign correction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_a_reg  <= '0;
      s1_b_reg  <= '0;
      s1_op_reg <= MUL;
    end else if (bus.M_en) begin
      s1_a_reg  <= bus.E_src1;
      s1_b_reg  <= bus.E_src2;
      s1_op_reg <= mul_op_e'(bus.E_mul_op);
    end
  end

  logic [W2-1:0] sum;

  // S2 combinational: full 2W product, then low word or corrected high word.
  always_comb begin
    sum = W2'(part[0])
        + (W2'(part[1]) << HALF)
        + (W2'(part[2]) << HALF)
        + {part[3], {WIDTH{1'b0}}};
    if (s1_op_reg == MUL) begin
      s2_next = sum[WIDTH-1:0];
    end else begin
      s2_next = WIDTH'(mul_hi_correct(MUL_MAX_WIDTH'(sum[W2-1:WIDTH]),
                                      MUL_MAX_WIDTH'(s1_a_reg),
                                      MUL_MAX_WIDTH'(s1_b_reg),
                                      s1_a_reg[WIDTH-1],
                                      s1_b_reg[WIDTH-1],
                                      s1_op_reg));
    end
  end
`else
  // Without the high-word path the op code carries no information.
  logic unused_op;
  assign unused_op = ^bus.E_mul_op;

  // S2 combinational: only the low word is needed, so p_hh never matters.
  always_comb begin
    s2_next = part[0] + (part[1] << HALF) + (part[2] << HALF);
  end
`endif

  // Stage 0 is the S2 result register, the rest are the extra stages.
  for (gi = 0; gi < OUT_STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    if (gi == 0) begin : g_from_sum
      assign data_in  = s2_next;
      assign valid_in = s1_valid_reg;
    end else begin : g_from_prev
      assign data_in  = g_stage[gi-1].data_reg;
      assign valid_in = g_stage[gi-1].valid_reg;
    end

    // Data advances on M_en; valid additionally cleared by flush.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        if (bus.M_en) begin
          data_reg <= data_in;
        end
        if (bus.M_flush) begin
          valid_reg <= 1'b0;
        end else if (bus.M_en) begin
          valid_reg <= valid_in;
        end
      end
    end
  end

  assign bus.W_mul_result = g_stage[OUT_STAGES-1].data_reg;
  assign bus.W_mul_valid  = g_stage[OUT_STAGES-1].valid_reg;

endmodule

// File: tb/tb_platform_nios_cpu_mul_pipe.sv
// Self-checking bench for platform_nios_cpu_mul_pipe (WIDTH=32).
// A queue-based reference model predicts every output cycle; directed
// cases pin the model against hand-computed literals.
module tb_platform_nios_cpu_mul_pipe;

  parameter int PIPE_EXTRA = 0;
  localparam int LAT = 2 + PIPE_EXTRA;
`ifdef NIOS_MUL_HI_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  platform_nios_cpu_mul_pipe_if #(.WIDTH(32)) bus ();

  platform_nios_cpu_mul_pipe #(.WIDTH(32), .PIPE_EXTRA(PIPE_EXTRA)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
    logic [63:0] prod;
    prod = {32'b0, a} * {32'b0, b};
    if (!HI_EN || op == 2'd0) return prod[31:0];
    case (op)
      2'd1:    prod = 64'(longint'($signed(a)) * longint'($signed(b)));
      2'd2:    prod = 64'(longint'($signed(a)) * longint'({32'b0, b}));
      default: prod = {32'b0, a} * {32'b0, b};
    endcase
    return prod[63:32];
  endfunction

  // Model: each accepted op ages by one per enabled edge; visible at age LAT.
  typedef struct {
    logic [31:0] res;
    int          age;
  } ent_t;
  ent_t        q[$];
  logic [31:0] seen[$];
  logic        samp_v = 1'b0;
  logic [31:0] samp_r = '0;
  bit          checking = 1'b0;

  function automatic bit model_valid();
    return (q.size() > 0) && (q[0].age == LAT);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
    end else begin
      if (samp_v && bus.M_en && !bus.M_flush) seen.push_back(samp_r);
      if (bus.M_flush) begin
        q.delete();
      end else if (bus.M_en) begin
        foreach (q[i]) q[i].age++;
        while (q.size() > 0 && q[0].age > LAT) void'(q.pop_front());
        if (bus.E_mul_valid)
          q.push_back('{ref_result(bus.E_src1, bus.E_src2, bus.E_mul_op), 1});
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    samp_v = bus.W_mul_valid;
    samp_r = bus.W_mul_result;
    if (checking) begin
      chk("cyc_valid", {31'b0, bus.W_mul_valid}, {31'b0, model_valid()});
      if (model_valid()) chk("cyc_result", bus.W_mul_result, q[0].res);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.E_mul_valid = 1'b0;
    bus.M_en        = 1'b1;
    bus.M_flush     = 1'b0;
  endtask

  // Single op on an idle pipe: checks exact latency, value and no repeat.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [31:0] lit, input string name);
    chk({name, "_model"}, ref_result(a, b, op), lit);
    bus.E_src1 = a; bus.E_src2 = b; bus.E_mul_op = op;
    bus.E_mul_valid = 1'b1; bus.M_en = 1'b1; bus.M_flush = 1'b0;
    step();
    bus.E_mul_valid = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      chk({name, "_early"}, {31'b0, bus.W_mul_valid}, 32'd0);
      step();
    end
    chk({name, "_valid"}, {31'b0, bus.W_mul_valid}, 32'd1);
    chk({name, "_result"}, bus.W_mul_result, lit);
    step();
    chk({name, "_once"}, {31'b0, bus.W_mul_valid}, 32'd0);
  endtask

  task automatic drain();
    idle_inputs();
    for (int k = 0; k < LAT + 2; k++) step();
  endtask

  initial begin
    bus.E_src1 = '0; bus.E_src2 = '0; bus.E_mul_op = 2'd0;
    bus.E_mul_valid = 1'b0; bus.M_en = 1'b1; bus.M_flush = 1'b0;

    // Reset state
    repeat (3) step();
    chk("reset_valid", {31'b0, bus.W_mul_valid}, 32'd0);
    chk("reset_result", bus.W_mul_result, 32'd0);
    #2 reset_n = 1'b1;
    step();
    checking = 1'b1;

    // Directed corner products
    run_one(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 32'h00000001, "ones_mul");
    run_one(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, HI_EN ? 32'hFFFFFFFE : 32'h00000001, "ones_mulxuu");
    run_one(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd1, HI_EN ? 32'h00000000 : 32'h00000001, "ones_mulxss");
    run_one(32'h80000000, 32'h80000000, 2'd1, HI_EN ? 32'h40000000 : 32'h00000000, "min_mulxss");
    run_one(32'h80000000, 32'h80000000, 2'd2, HI_EN ? 32'hC0000000 : 32'h00000000, "min_mulxsu");
    run_one(32'h80000000, 32'h80000000, 2'd3, HI_EN ? 32'h40000000 : 32'h00000000, "min_mulxuu");

    // Back-to-back stream with a three-cycle stall
    seen.delete();
    for (int i = 3; i <= 7; i++) begin
      bus.E_src1 = 32'(i); bus.E_src2 = 32'd5; bus.E_mul_op = 2'd0;
      bus.E_mul_valid = 1'b1;
      if (i == 6) begin
        bus.M_en = 1'b0;
        repeat (3) step();
        bus.M_en = 1'b1;
      end
      step();
    end
    drain();
    chk("stream_count", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("stream_order", (i < seen.size()) ? seen[i] : 32'hDEADBEEF, 32'(15 + 5 * i));

    // Flush with ops in flight plus one new op
    for (int i = 0; i < LAT - 1; i++) begin
      bus.E_src1 = 32'(i + 2); bus.E_src2 = 32'd3; bus.E_mul_op = 2'd0;
      bus.E_mul_valid = 1'b1;
      step();
    end
    bus.E_src1 = 32'd11; bus.M_flush = 1'b1;
    step();
    idle_inputs();
    for (int k = 0; k < LAT + 2; k++) begin
      chk("flush_quiet", {31'b0, bus.W_mul_valid}, 32'd0);
      step();
    end
    run_one(32'd6, 32'd7, 2'd0, 32'd42, "post_flush");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.E_src1 = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      bus.E_src2 = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      bus.E_mul_op    = 2'($urandom_range(0, 3));
      bus.E_mul_valid = ($urandom_range(0, 9) < 7);
      bus.M_en        = ($urandom_range(0, 9) < 8);
      bus.M_flush     = ($urandom_range(0, 29) == 0);
      step();
    end
    drain();

    // Asynchronous reset between edges with ops in flight
    bus.E_src1 = 32'd13; bus.E_src2 = 32'd17; bus.E_mul_op = 2'd0;
    bus.E_mul_valid = 1'b1;
    step();
    step();
    bus.E_mul_valid = 1'b0;
    step();
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, bus.W_mul_valid}, 32'd0);
    chk("async_rst_result", bus.W_mul_result, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    step();
    run_one(32'd9, 32'd9, 2'd0, 32'd81, "post_reset");

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
